// File: rtl/win_seq_pkg.sv
// -----------------------------------------------------------------------------
// win_seq_pkg
// Shared definitions for the window sequencing controller: default parameter
// constants and the controller state encoding.
//
// Configuration macro: WIN_SEQ_FLUSH_EN adds the FLUSH state, which zero-pads
// the shift window for WIN_DEPTH cycles after every row.
// -----------------------------------------------------------------------------
package win_seq_pkg;

   localparam int DEF_PIXEL_WIDTH = 11;
   localparam int DEF_IMG_WIDTH   = 640;
   localparam int DEF_IMG_HEIGHT  = 480;
   localparam int DEF_WIN_DEPTH   = 258;
   localparam int DEF_EOL_GAP     = 4;

`ifdef WIN_SEQ_FLUSH_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      EOL   = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      EOL   = 3'd2,
      DONE  = 3'd4
   } state_t;
`endif

endpackage : win_seq_pkg

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Enabled up-counter that returns to zero after reaching a run-time terminal
// count. wrap is a combinational pulse marking the enabled cycle in which the
// count sits at the terminal value (the last cycle of a full period).
//
// Ports
//   clock  in   clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   en     in   advance the count this cycle
//   term   in   terminal count (period is term+1 enabled cycles)
//   count  out  current count
//   wrap   out  en & (count == term)
// -----------------------------------------------------------------------------
module wrap_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   assign wrap = en && (count == term);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule : wrap_counter

// File: rtl/window_seq_ctrl.sv
// -----------------------------------------------------------------------------
// window_seq_ctrl
// Sequences pixel columns through a shift-window datapath and its line buffer.
// One column is accepted per transfer (in_valid & in_ready) while in RUN; each
// row ends with an optional zero-pad flush (WIN_SEQ_FLUSH_EN) followed by an
// EOL_GAP-cycle turnaround, and the frame closes with a one-cycle frame_done.
//
// Configuration macro: WIN_SEQ_FLUSH_EN (undefined by default: no FLUSH state,
// pad_sel tied low).
//
// Ports
//   clock       in   single clock
//   rst         in   asynchronous active-high reset
//   start       in   frame start request, honoured only in IDLE
//   in_valid    in   upstream column valid
//   in_ready    out  controller accepts a column (RUN only)
//   win_clken   out  window shift enable (transfer, or every FLUSH cycle)
//   pad_sel     out  zero-pad select for the window inputs during FLUSH
//   lb_addr     out  line-buffer column address (current column)
//   lb_wr_en    out  line-buffer write enable (transfer)
//   row_cnt     out  current row
//   win_valid   out  window holds a full, valid neighbourhood
//   busy        out  frame in progress (any state but IDLE)
//   frame_done  out  one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module window_seq_ctrl
   import win_seq_pkg::*;
#(
   parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
   parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
   parameter int WIN_DEPTH   = DEF_WIN_DEPTH,
   parameter int EOL_GAP     = DEF_EOL_GAP
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          win_clken,
   output logic                          pad_sel,
   output logic [$clog2(IMG_WIDTH)-1:0]  lb_addr,
   output logic                          lb_wr_en,
   output logic [$clog2(IMG_HEIGHT)-1:0] row_cnt,
   output logic                          win_valid,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int COL_W    = $clog2(IMG_WIDTH);
   localparam int ROW_W    = $clog2(IMG_HEIGHT);
   localparam int GAP_MAX  = (WIN_DEPTH > EOL_GAP) ? WIN_DEPTH : EOL_GAP;
   localparam int GAP_W    = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
   localparam int EOL_TERM = (EOL_GAP > 0) ? EOL_GAP - 1 : 0;

   // The controller never touches pixel data; PIXEL_WIDTH is carried for the
   // surrounding datapath and only sanity-checked here.
   if (PIXEL_WIDTH < 1 || IMG_WIDTH < 2 || IMG_HEIGHT < 2 || WIN_DEPTH < 1 ||
       EOL_GAP < 0) begin : g_bad_params
      $error("window_seq_ctrl: illegal parameter combination");
   end

   state_t            state, state_d;
   logic              transfer;
   logic              col_wrap;
   logic              in_flush;
   logic              flush_next;
   logic              gap_en;
   logic              gap_wrap;
   logic [GAP_W-1:0]  gap_term;
   logic [GAP_W-1:0]  gap_cnt;
   logic              last_row;
   logic              row_end;
   logic              win_valid_d;

`ifdef WIN_SEQ_FLUSH_EN
   assign in_flush   = (state == FLUSH);
   assign flush_next = col_wrap;   // a row-closing transfer always enters FLUSH
`else
   assign in_flush   = 1'b0;
   assign flush_next = 1'b0;
`endif

   assign in_ready   = (state == RUN);
   assign transfer   = in_valid && in_ready;
   assign lb_wr_en   = transfer;
   assign win_clken  = transfer || in_flush;
   assign pad_sel    = in_flush;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);
   assign last_row   = (row_cnt == ROW_W'(IMG_HEIGHT - 1));

   // Column counter: drives lb_addr directly, wraps on the row's last transfer.
   wrap_counter #(.WIDTH(COL_W)) u_col_cnt (
      .clock (clock),
      .rst   (rst),
      .en    (transfer),
      .term  (COL_W'(IMG_WIDTH - 1)),
      .count (lb_addr),
      .wrap  (col_wrap)
   );

   // One counter times both FLUSH and EOL; it is back at zero when FLUSH hands
   // over to EOL, so only the terminal count needs to change with the state.
   assign gap_en   = (state == EOL) || in_flush;
   assign gap_term = in_flush ? GAP_W'(WIN_DEPTH - 1) : GAP_W'(EOL_TERM);

   wrap_counter #(.WIDTH(GAP_W)) u_gap_cnt (
      .clock (clock),
      .rst   (rst),
      .en    (gap_en),
      .term  (gap_term),
      .count (gap_cnt),
      .wrap  (gap_wrap)
   );

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state;
      row_end = 1'b0;
      unique case (state)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (col_wrap) begin
`ifdef WIN_SEQ_FLUSH_EN
               state_d = FLUSH;
`else
               if (EOL_GAP == 0) row_end = 1'b1;
               else              state_d = EOL;
`endif
            end
         end
`ifdef WIN_SEQ_FLUSH_EN
         FLUSH: begin
            if (gap_wrap) begin
               if (EOL_GAP == 0) row_end = 1'b1;
               else              state_d = EOL;
            end
         end
`endif
         EOL:  if (gap_wrap) row_end = 1'b1;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (row_end) state_d = last_row ? DONE : RUN;
   end

   // A window is complete once WIN_DEPTH columns of the third or later row have
   // shifted in; the column that opens a flush is suppressed because FLUSH
   // cycles must never present a valid window.
   assign win_valid_d = transfer && !flush_next &&
                        (int'(lb_addr) >= WIN_DEPTH - 1) && (int'(row_cnt) >= 2);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         row_cnt   <= '0;
         win_valid <= 1'b0;
      end else begin
         state     <= state_d;
         win_valid <= win_valid_d;
         if (row_end) row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
      end
   end

endmodule : window_seq_ctrl

// File: tb/tb_window_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_seq_ctrl
// Scoreboarded bench for window_seq_ctrl at IMG_WIDTH=8, IMG_HEIGHT=4,
// WIN_DEPTH=4, EOL_GAP=2. Expected (row, column) pairs for every transfer of a
// frame are queued up front and popped as the DUT accepts columns. Follows the
// WIN_SEQ_FLUSH_EN macro for the flush expectations.
// -----------------------------------------------------------------------------
module tb_window_seq_ctrl;

   localparam int IMG_W = 8;
   localparam int IMG_H = 4;
   localparam int WIN_D = 4;
   localparam int GAP   = 2;
`ifdef WIN_SEQ_FLUSH_EN
   localparam int FLUSH_CYC = WIN_D;
`else
   localparam int FLUSH_CYC = 0;
`endif
   localparam int GAP_EXP = FLUSH_CYC + GAP;
   localparam int WV_EXP  = (IMG_H - 2) * (IMG_W - (WIN_D - 1)) -
                            ((FLUSH_CYC > 0) ? (IMG_H - 2) : 0);

   typedef struct {
      int row;
      int col;
   } xfer_t;

   logic                     clock = 1'b0;
   logic                     rst;
   logic                     start;
   logic                     in_valid;
   logic                     in_ready;
   logic                     win_clken;
   logic                     pad_sel;
   logic [$clog2(IMG_W)-1:0] lb_addr;
   logic                     lb_wr_en;
   logic [$clog2(IMG_H)-1:0] row_cnt;
   logic                     win_valid;
   logic                     busy;
   logic                     frame_done;

   int checks = 0;
   int errors = 0;

   xfer_t exp_q[$];

   window_seq_ctrl #(
      .PIXEL_WIDTH (11),
      .IMG_WIDTH   (IMG_W),
      .IMG_HEIGHT  (IMG_H),
      .WIN_DEPTH   (WIN_D),
      .EOL_GAP     (GAP)
   ) dut (
      .clock      (clock),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_clken  (win_clken),
      .pad_sel    (pad_sel),
      .lb_addr    (lb_addr),
      .lb_wr_en   (lb_wr_en),
      .row_cnt    (row_cnt),
      .win_valid  (win_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   function automatic logic [13:0] out_vec();
      return {in_ready, win_clken, pad_sel, lb_addr, lb_wr_en, row_cnt,
              win_valid, busy, frame_done};
   endfunction

   // Runs one whole frame. toggle: in_valid only on every other cycle.
   // poke_start: pulse start mid-frame, which must be ignored.
   task automatic run_frame(input string name, input bit toggle, input bit poke_start);
      int    exp_addr = 0;
      bit    exp_wv   = 1'b0;
      bit    exp_wv_next;
      int    wv_cnt   = 0;
      int    low_run  = 0;
      int    cyc      = 0;
      int    xfers    = 0;
      bit    in_gap   = 1'b0;
      bit    done     = 1'b0;
      bit    poked    = 1'b0;
      xfer_t e;

      exp_q.delete();
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) exp_q.push_back('{row: r, col: c});

      @(negedge clock);
      start    = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL %s idle_before_start: busy=%b in_ready=%b, required 0 0", name, busy, in_ready);
      @(negedge clock);

      while (!done && cyc < 400) begin
         in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         start    = poke_start && !poked && xfers == 10;
         if (start) poked = 1'b1;
         #1;
         cyc++;

         checks++;
         if (win_valid !== exp_wv) begin
            errors++;
            $display("FAIL %s win_valid cyc%0d: got %b, required %b", name, cyc, win_valid, exp_wv);
         end
         if (win_valid === 1'b1) wv_cnt++;
         checks++;
         if (int'(lb_addr) !== exp_addr) begin
            errors++;
            $display("FAIL %s lb_addr cyc%0d: got %0d, required %0d", name, cyc, lb_addr, exp_addr);
         end

         if (frame_done === 1'b1) begin
            done = 1'b1;
            checks++;
            if (!in_gap || low_run != GAP_EXP) begin
               errors++;
               $display("FAIL %s last_row_gap: got %0d low cycles (gap seen %b), required %0d", name, low_run, in_gap, GAP_EXP);
            end
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL %s transfer_count: got %0d, required %0d", name, xfers, IMG_W * IMG_H);
            end
         end else begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy cyc%0d: got %b, required 1", name, cyc, busy);
            end
            if (in_gap && in_ready === 1'b1) begin
               checks++;
               if (low_run != GAP_EXP) begin
                  errors++;
                  $display("FAIL %s row_gap: got %0d low cycles, required %0d", name, low_run, GAP_EXP);
               end
               in_gap = 1'b0;
            end else if (in_gap) begin
               low_run++;
               checks++;
               if (pad_sel !== (low_run <= FLUSH_CYC) || win_clken !== (low_run <= FLUSH_CYC) ||
                   lb_wr_en !== 1'b0) begin
                  errors++;
                  $display("FAIL %s gap_outputs gap_cyc%0d: pad_sel=%b win_clken=%b lb_wr_en=%b, required %b %b 0",
                           name, low_run, pad_sel, win_clken, lb_wr_en,
                           low_run <= FLUSH_CYC, low_run <= FLUSH_CYC);
               end
            end
         end

         exp_wv_next = 1'b0;
         if (in_valid && in_ready === 1'b1) begin
            xfers++;
            checks++;
            if (lb_wr_en !== 1'b1 || win_clken !== 1'b1 || pad_sel !== 1'b0) begin
               errors++;
               $display("FAIL %s xfer_strobes: lb_wr_en=%b win_clken=%b pad_sel=%b, required 1 1 0", name, lb_wr_en, win_clken, pad_sel);
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s extra_transfer: got transfer %0d, required %0d max", name, xfers, IMG_W * IMG_H);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (int'(row_cnt) !== e.row || int'(lb_addr) !== e.col) begin
                  errors++;
                  $display("FAIL %s xfer_pos: got row %0d col %0d, required row %0d col %0d", name, row_cnt, lb_addr, e.row, e.col);
               end
               exp_wv_next = (e.col >= WIN_D - 1) && (e.row >= 2) &&
                             !(FLUSH_CYC > 0 && e.col == IMG_W - 1);
               exp_addr = (e.col + 1) % IMG_W;
               if (e.col == IMG_W - 1) begin
                  in_gap  = 1'b1;
                  low_run = 0;
               end
            end
         end else if (in_ready === 1'b1) begin
            checks++;
            if (lb_wr_en !== 1'b0 || win_clken !== 1'b0) begin
               errors++;
               $display("FAIL %s bubble_strobes: lb_wr_en=%b win_clken=%b, required 0 0", name, lb_wr_en, win_clken);
            end
         end
         exp_wv = exp_wv_next;
         @(negedge clock);
      end

      start    = 1'b0;
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s frame_done_timeout: got none in %0d cycles, required one", name, cyc);
      end
      #1;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: frame_done=%b busy=%b in_ready=%b, required 0 0 0", name, frame_done, busy, in_ready);
      end
      checks++;
      if (wv_cnt != WV_EXP) begin
         errors++;
         $display("FAIL %s win_valid_count: got %0d, required %0d", name, wv_cnt, WV_EXP);
      end
   endtask

   task automatic test_reset();
      int  cyc = 0;
      bit  hit = 1'b0;
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_vec() !== '0) begin
         errors++;
         $display("FAIL reset_initial: outputs %h, required 0", out_vec());
      end
      @(negedge clock);
      rst = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start    = 1'b0;
      in_valid = 1'b1;
      while (!hit && cyc < 200) begin
         #1;
         if (row_cnt == 2 && lb_addr == 5) hit = 1'b1;
         else begin
            cyc++;
            @(negedge clock);
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reset_reach_row2: got row %0d col %0d, required row 2 col 5", row_cnt, lb_addr);
      end
      checks++;
      if (win_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_win_valid: got %b, required 1", win_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (out_vec() !== '0) begin
         errors++;
         $display("FAIL reset_async_midrow: outputs %h, required 0", out_vec());
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_vec() !== '0) begin
         errors++;
         $display("FAIL reset_next_cycle: outputs %h, required 0", out_vec());
      end
      @(negedge clock);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || row_cnt !== '0 || lb_addr !== '0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b row=%0d col=%0d, required 0 0 0", busy, row_cnt, lb_addr);
      end
   endtask

   task automatic test_streaming();
      run_frame("streaming", 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_frame("backpressure", 1'b1, 1'b0);
   endtask

   task automatic test_start_while_busy();
      run_frame("start_busy", 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_frame("back_to_back", 1'b1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_start_while_busy();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_window_seq_ctrl
